// File: rtl/led_arb_pkg.sv
// led_arb_pkg: shared state encoding, default LED bank width and the
// sizing helper used by the LED share arbiter and its round-robin picker.
package led_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        GAP  = 2'd2
    } arb_state_t;

    localparam int LED_W_DEFAULT = 16;

    // Bits needed to hold values 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_arb_rr_pick.sv
// led_arb_rr_pick: combinational round-robin picker. Returns the first set
// request at or above ptr, wrapping to index 0, as a one-hot winner.
module led_arb_rr_pick
    import led_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = cnt_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic               valid
);

    // Upper pass covers ptr..NUM_REQ-1, lower pass covers the wrapped part.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!valid && req[i] && (i >= int'(ptr))) begin
                winner[i] = 1'b1;
                valid     = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!valid && req[i] && (i < int'(ptr))) begin
                winner[i] = 1'b1;
                valid     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/led_share_arbiter.sv
// led_share_arbiter: time-slices the LED bank between NUM_REQ pattern sources.
// Define LED_ARB_PRIO_EN to make requester 0 high priority with preemption.
module led_share_arbiter
    import led_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int LED_W     = LED_W_DEFAULT,
    parameter int MIN_HOLD  = 8,
    parameter int MAX_SLICE = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*LED_W-1:0] pattern,
    output logic [NUM_REQ-1:0]       grant,
    output logic                     busy,
    output logic [LED_W-1:0]         LED,
    output logic                     slice_end
);

    localparam int CNT_W = cnt_width(MAX_SLICE);
    localparam int PTR_W = cnt_width(NUM_REQ);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_SLICE - 1);
    localparam logic [CNT_W-1:0] HOLD_MIN = CNT_W'(MIN_HOLD - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);

    arb_state_t         state;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   owner;
    logic [CNT_W-1:0]   cnt;

    logic [PTR_W-1:0]   pick_ptr;
    logic [NUM_REQ-1:0] win_onehot;
    logic               win_valid;
    logic [PTR_W-1:0]   win_idx;
    logic [PTR_W-1:0]   next_ptr;
    logic               owner_req;
    logic [LED_W-1:0]   owner_pattern;
    logic               hold_met;
    logic               rel_now;

    led_arb_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .req    (req),
        .ptr    (pick_ptr),
        .winner (win_onehot),
        .valid  (win_valid)
    );

    // A pending high-priority request starts the search at 0 so it always wins.
    always_comb begin
`ifdef LED_ARB_PRIO_EN
        pick_ptr = req[0] ? '0 : rr_ptr;
`else
        pick_ptr = rr_ptr;
`endif
    end

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_onehot[i]) begin
                win_idx = PTR_W'(i);
            end
        end
    end

    always_comb begin
        owner_req     = 1'b0;
        owner_pattern = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner == PTR_W'(i)) begin
                owner_req     = req[i];
                owner_pattern = pattern[i*LED_W +: LED_W];
            end
        end
    end

    // Priority owner 0 keeps the pointer at 0 instead of handing it onward.
    always_comb begin
        if (owner == PTR_LAST) begin
            next_ptr = '0;
        end else begin
            next_ptr = owner + 1'b1;
        end
`ifdef LED_ARB_PRIO_EN
        if (owner == '0) begin
            next_ptr = '0;
        end
`endif
    end

    always_comb begin
        hold_met = (cnt >= HOLD_MIN);
        rel_now  = (!owner_req && hold_met) || (cnt == CNT_MAX);
`ifdef LED_ARB_PRIO_EN
        if (req[0] && (owner != '0) && hold_met) begin
            rel_now = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            cnt       <= '0;
            grant     <= '0;
            busy      <= 1'b0;
            LED       <= '0;
            slice_end <= 1'b0;
        end else begin
            slice_end <= 1'b0;
            case (state)
                IDLE: begin
                    LED <= '0;
                    if (win_valid) begin
                        grant <= win_onehot;
                        busy  <= 1'b1;
                        owner <= win_idx;
                        cnt   <= '0;
                        state <= OWN;
                    end
                end
                OWN: begin
                    if (rel_now) begin
                        grant     <= '0;
                        busy      <= 1'b0;
                        LED       <= '0;
                        slice_end <= 1'b1;
                        rr_ptr    <= next_ptr;
                        state     <= GAP;
                    end else begin
                        LED <= owner_pattern;
                        if (cnt != CNT_MAX) begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                GAP: begin
                    LED   <= '0;
                    state <= IDLE;
                end
                default: begin
                    grant <= '0;
                    busy  <= 1'b0;
                    LED   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Structural invariants of the grant/LED outputs.
    a_grant_onehot : assert property (@(posedge clk) $onehot0(grant));
    a_busy_match   : assert property (@(posedge clk) busy == (grant != '0));
    a_grant_own    : assert property (@(posedge clk) disable iff (rst)
                                      (state != OWN) |-> (grant == '0));
    a_blank_led    : assert property (@(posedge clk) disable iff (rst)
                                      (state != OWN) |-> (LED == '0));
    a_pulse_gap    : assert property (@(posedge clk) disable iff (rst)
                                      slice_end |-> (state == GAP));

endmodule
